// File: rtl/mem_req_unit.sv
// Data-memory request initiator: accepts one load/store op at a time, forms
// byte strobes and lane-replicated store data, drives a req/addr_ok bus
// handshake and hands per-response load-extraction flags back on data_ok.
module mem_req_unit #(
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  output logic        op_ready,
  input  logic        op_we,
  input  logic [1:0]  op_size,
  input  logic        op_signed,
  input  logic [31:0] op_addr,
  input  logic [31:0] op_wdata,
  input  logic        flush,
  output logic        req,
  output logic        req_wr,
  output logic [1:0]  req_size,
  output logic [31:0] req_addr,
  output logic [3:0]  req_wstrb,
  output logic [31:0] req_wdata,
  input  logic        addr_ok,
  input  logic        data_ok,
  output logic        resp_valid,
  output logic        resp_wr,
  output logic [4:0]  resp_flag,
  output logic        ale
);

  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CW = 3;

  typedef enum logic {IDLE, REQ} state_t;

  // One slot per issued request; discard hides the response from ME.
  typedef struct packed {
    logic [4:0] flag;
    logic       wr;
    logic       discard;
  } entry_t;

  state_t        state, state_nx;
  entry_t        fifo [MAX_OUTSTANDING];
  entry_t        head;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          req_flushed;
  logic [4:0]    req_flag;
  logic          accept, misaligned, push, pop;
  logic [1:0]    size_eff;
  logic [3:0]    wstrb_d;
  logic [31:0]   wdata_d;
  logic [4:0]    flag_d;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + PW'(1);
  endfunction

  assign size_eff   = (op_size == 2'd3) ? 2'd2 : op_size;
  assign misaligned = ((size_eff == 2'd1) && op_addr[0]) ||
                      ((size_eff == 2'd2) && (op_addr[1:0] != 2'b00));
  // A request sitting in REQ already owns a slot even though it is not yet
  // counted; in practice op_ready is only high in IDLE, so this term is 0.
  assign op_ready   = (state == IDLE) && !flush &&
                      ((count + CW'(state == REQ)) < CW'(MAX_OUTSTANDING));
  assign accept     = op_valid && op_ready;
  assign push       = (state == REQ) && addr_ok;
  assign pop        = data_ok && (count != '0);
  assign head       = fifo[rd_ptr];

  assign req        = (state == REQ);
  assign resp_valid = pop && !head.discard;
  assign resp_wr    = head.wr;
  assign resp_flag  = head.flag;

  // Lane decode: strobes and replicated data for stores, extraction flag for loads.
  always_comb begin
    wstrb_d = 4'b0000;
    wdata_d = 32'h0;
    flag_d  = 5'b00000;
    case (size_eff)
      2'd0: begin
        if (op_we) begin
          wstrb_d = 4'b0001 << op_addr[1:0];
          wdata_d = {4{op_wdata[7:0]}};
        end else begin
          flag_d = {op_signed, 1'b1, 1'b0, op_addr[1:0]};
        end
      end
      2'd1: begin
        if (op_we) begin
          wstrb_d = op_addr[1] ? 4'b1100 : 4'b0011;
          wdata_d = {2{op_wdata[15:0]}};
        end else begin
          flag_d = {op_signed, 1'b0, 1'b1, op_addr[1], 1'b0};
        end
      end
      default: begin
        if (op_we) begin
          wstrb_d = 4'b1111;
          wdata_d = op_wdata;
        end
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next state: aligned accept issues a request, addr_ok retires it.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept && !misaligned) state_nx = REQ;
      REQ:     if (addr_ok) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Request fields are captured on accept and held untouched while in REQ.
  always_ff @(posedge clk) begin
    if (reset) begin
      req_wr    <= 1'b0;
      req_size  <= 2'd0;
      req_addr  <= 32'h0;
      req_wstrb <= 4'h0;
      req_wdata <= 32'h0;
      req_flag  <= 5'h0;
    end else if (accept && !misaligned) begin
      req_wr    <= op_we;
      req_size  <= size_eff;
      req_addr  <= op_addr;
      req_wstrb <= wstrb_d;
      req_wdata <= wdata_d;
      req_flag  <= flag_d;
    end
  end

  // Misaligned accept raises a one-cycle exception pulse instead of a request.
  always_ff @(posedge clk) begin
    if (reset) ale <= 1'b0;
    else       ale <= accept && misaligned;
  end

  // Remember a flush that hit while the request waited on the bus.
  always_ff @(posedge clk) begin
    if (reset)              req_flushed <= 1'b0;
    else if (state == IDLE) req_flushed <= 1'b0;
    else if (flush)         req_flushed <= 1'b1;
  end

  // Outstanding-response FIFO: push on grant, pop on data_ok, flush marks all.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) fifo[i] <= '0;
    end else begin
      if (flush)
        for (int i = 0; i < MAX_OUTSTANDING; i++) fifo[i].discard <= 1'b1;
      if (push) begin
        fifo[wr_ptr] <= '{flag: req_flag, wr: req_wr, discard: req_flushed | flush};
        wr_ptr       <= next_ptr(wr_ptr);
      end
      if (pop) rd_ptr <= next_ptr(rd_ptr);
      count <= count + CW'(push) - CW'(pop);
    end
  end

endmodule

// File: tb/tb_mem_req_unit.sv
// Scoreboarded bench for mem_req_unit: directed scenarios followed by random
// traffic, all checked by a negedge monitor against a transaction-level model.
module tb_mem_req_unit;
  localparam int MAX = 2;

  logic        clk = 1'b0, reset = 1'b1;
  logic        op_valid = 1'b0, op_we = 1'b0, op_signed = 1'b0, flush = 1'b0;
  logic [1:0]  op_size = 2'd0;
  logic [31:0] op_addr = 32'h0, op_wdata = 32'h0;
  logic        addr_ok = 1'b0, data_ok = 1'b0;
  logic        op_ready, req, req_wr, resp_valid, resp_wr, ale;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wstrb;
  logic [4:0]  resp_flag;

  mem_req_unit #(.MAX_OUTSTANDING(MAX)) dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op_ready(op_ready),
    .op_we(op_we), .op_size(op_size), .op_signed(op_signed), .op_addr(op_addr),
    .op_wdata(op_wdata), .flush(flush), .req(req), .req_wr(req_wr),
    .req_size(req_size), .req_addr(req_addr), .req_wstrb(req_wstrb),
    .req_wdata(req_wdata), .addr_ok(addr_ok), .data_ok(data_ok),
    .resp_valid(resp_valid), .resp_wr(resp_wr), .resp_flag(resp_flag), .ale(ale)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic [4:0]  flag;
  } req_t;

  typedef struct {
    logic       wr;
    logic [4:0] flag;
    logic       disc;
  } resp_t;

  int    tests = 0, fails = 0;
  req_t  pend_q[$];
  resp_t resp_q[$];
  bit    pend_disc = 0, ale_exp = 0, prev_reset = 0, started = 0, auto_bus = 0;

  // Reference: what the bus should see for an op, straight from the op rules.
  function automatic void model_op(input logic we, input logic [1:0] size, input logic sgn,
                                   input logic [31:0] addr, input logic [31:0] wd,
                                   output req_t r, output bit mis);
    int         sz;
    int         hi;
    logic [1:0] off;
    sz  = (size == 2'd3) ? 2 : int'(size);
    off = addr[1:0];
    hi  = int'(addr[1]);
    mis = (sz == 1 && (addr % 2) != 0) || (sz == 2 && (addr % 4) != 0);
    r.wr = we; r.size = 2'(sz); r.addr = addr;
    r.wstrb = 4'h0; r.wdata = 32'h0; r.flag = 5'h0;
    case (sz)
      0: if (we) begin
           r.wstrb = 4'(1 << off);
           r.wdata = {24'h0, wd[7:0]} * 32'h01010101;
         end else r.flag = {sgn, 1'b1, 1'b0, off};
      1: if (we) begin
           r.wstrb = 4'(3 << (2 * hi));
           r.wdata = {16'h0, wd[15:0]} * 32'h00010001;
         end else r.flag = {sgn, 1'b0, 1'b1, addr[1], 1'b0};
      default: if (we) begin
           r.wstrb = 4'hf;
           r.wdata = wd;
         end
    endcase
  endfunction

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compare outputs against the model, then advance the model.
  initial begin
    req_t  r;
    resp_t e;
    bit    exp_ready, mis;
    forever begin
      @(negedge clk);
      exp_ready = (pend_q.size() == 0) && !flush && (resp_q.size() < MAX);
      if (prev_reset) started = 1;
      if (started) begin
        if (prev_reset)
          chk("reset_fields", {req_wr, req_size, req_addr, req_wstrb, req_wdata}, 96'h0);
        chk("op_ready", op_ready, exp_ready);
        chk("req", req, pend_q.size() != 0);
        if (pend_q.size() != 0)
          chk("req_fields", {req_wr, req_size, req_addr, req_wstrb, req_wdata},
              {pend_q[0].wr, pend_q[0].size, pend_q[0].addr, pend_q[0].wstrb, pend_q[0].wdata});
        chk("ale", ale, ale_exp);
        if (data_ok && resp_q.size() != 0) begin
          chk("resp_valid", resp_valid, !resp_q[0].disc);
          if (!resp_q[0].disc)
            chk("resp_data", {resp_wr, resp_flag}, {resp_q[0].wr, resp_q[0].flag});
        end else begin
          chk("resp_quiet", resp_valid, 1'b0);
        end
      end
      prev_reset = reset;
      if (reset) begin
        pend_q.delete(); resp_q.delete();
        ale_exp = 0; pend_disc = 0;
      end else begin
        if (data_ok && resp_q.size() != 0) void'(resp_q.pop_front());
        if (flush) begin
          foreach (resp_q[i]) resp_q[i].disc = 1'b1;
          if (pend_q.size() != 0) pend_disc = 1;
        end
        if (pend_q.size() != 0 && addr_ok) begin
          r = pend_q.pop_front();
          e.wr = r.wr; e.flag = r.flag; e.disc = pend_disc;
          resp_q.push_back(e);
        end
        ale_exp = 0;
        if (op_valid && exp_ready) begin
          model_op(op_we, op_size, op_signed, op_addr, op_wdata, r, mis);
          if (mis) ale_exp = 1;
          else begin
            pend_q.push_back(r);
            pend_disc = 0;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (auto_bus) begin
      addr_ok = ($urandom_range(0, 3) != 0);
      data_ok = ($urandom_range(0, 2) == 0);
    end
  endtask

  task automatic pulse_addr_ok(); addr_ok = 1; tick(); addr_ok = 0; endtask
  task automatic pulse_data_ok(); data_ok = 1; tick(); data_ok = 0; endtask

  // Offer an op until it is taken; a stuck handshake ends the run.
  task automatic do_op(input logic we, input logic [1:0] size, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wd);
    bit taken;
    op_valid = 1; op_we = we; op_size = size; op_signed = sgn;
    op_addr = addr; op_wdata = wd;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      taken = op_ready;
      tick();
      if (taken) begin
        op_valid = 0;
        return;
      end
    end
    $display("FAIL op_handshake: got no op_ready expected acceptance within 50 cycles");
    $fatal(1, "handshake timeout");
  endtask

  initial begin
    repeat (3) tick();
    reset = 0;
    tick();

    // Store byte at a high lane, held 3 cycles before the grant.
    do_op(1, 2'd0, 0, 32'h1003, 32'h000000A5);
    repeat (3) tick();
    pulse_addr_ok();
    pulse_data_ok();

    // Signed half load and unsigned byte load, responses in order.
    do_op(0, 2'd1, 1, 32'h2002, 32'h0);
    pulse_addr_ok();
    do_op(0, 2'd0, 0, 32'h2001, 32'h0);
    pulse_addr_ok();
    pulse_data_ok();
    pulse_data_ok();

    // Misaligned word load: exception pulse only.
    do_op(0, 2'd2, 0, 32'h3002, 32'h0);
    repeat (3) tick();
    pulse_data_ok();

    // Fill to MAX, hold an op that must wait, overlap grant with a response.
    do_op(0, 2'd2, 0, 32'h5000, 32'h0);
    pulse_addr_ok();
    do_op(0, 2'd0, 1, 32'h5003, 32'h0);
    pulse_addr_ok();
    op_valid = 1; op_we = 1; op_size = 2'd3; op_addr = 32'h5008; op_wdata = 32'h12345678;
    repeat (3) tick();
    pulse_data_ok();
    do_op(1, 2'd3, 0, 32'h5008, 32'h12345678);
    addr_ok = 1; data_ok = 1; tick(); addr_ok = 0; data_ok = 0;
    pulse_data_ok();
    pulse_data_ok();
    pulse_data_ok();

    // Flush while the request waits: it still completes but is discarded.
    do_op(0, 2'd1, 0, 32'h4002, 32'h0);
    tick();
    flush = 1; tick(); flush = 0;
    tick();
    pulse_addr_ok();
    pulse_data_ok();
    pulse_data_ok();

    // Reset with two outstanding, then a stray response.
    do_op(0, 2'd0, 0, 32'h6000, 32'h0);
    pulse_addr_ok();
    do_op(1, 2'd1, 0, 32'h6006, 32'hBEEF);
    pulse_addr_ok();
    reset = 1; tick(); reset = 0;
    pulse_data_ok();
    tick();

    // Random traffic.
    auto_bus = 1;
    for (int i = 0; i < 3000; i++) begin
      tick();
      op_valid  = $urandom_range(0, 1);
      op_we     = $urandom_range(0, 1);
      op_size   = 2'($urandom_range(0, 3));
      op_signed = $urandom_range(0, 1);
      op_addr   = $urandom;
      op_wdata  = $urandom;
      flush     = !data_ok && ($urandom_range(0, 19) == 0);
      reset     = ($urandom_range(0, 299) == 0);
    end
    auto_bus = 0;
    op_valid = 0; flush = 0; reset = 0; addr_ok = 0; data_ok = 0;
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
